// File: rtl/b16_ext_mailbox_if.sv
// Mailbox bus + local-side signal bundle.
// Ports: a/wr_b/rd_b/ble_b/bhe_b from bus master; rx_*/tx_*/irq local side.
interface b16_ext_mailbox_if #(
  parameter int l = 16
);
  logic [l-1:0] a;
  logic         wr_b;
  logic         rd_b;
  logic         ble_b;
  logic         bhe_b;
  logic         irq;
  logic [l-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [l-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport slave (
    input  a, wr_b, rd_b, ble_b, bhe_b,
    input  rx_ready, tx_data, tx_valid,
    output irq, rx_data, rx_valid, tx_ready
  );

  modport master (
    output a, wr_b, rd_b, ble_b, bhe_b,
    output rx_ready, tx_data, tx_valid,
    input  irq, rx_data, rx_valid, tx_ready
  );
endinterface

// File: rtl/b16_ext_mailbox.sv
// External-bus mailbox: RX/TX FIFOs, status, scratch.
// Ports: clk, reset (async high), bus (slave modport), d (tristate data).
module b16_ext_mailbox #(
  parameter int           l     = 16,
  parameter logic [l-3:0] BASE  = 14'h1FFE,
  parameter int           DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  b16_ext_mailbox_if.slave bus,
  inout  wire [l-1:0]   d
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic wr_s1, wr_s2, rd_s1, rd_s2;
  logic wr_fall, rd_fall, rd_rise;
  logic rd_arm;
  logic [1:0] rd_reg;

  logic [l-1:0] rx_mem [DEPTH];
  logic [l-1:0] tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [l-1:0] scratch;
  logic ovf, udf;

  logic sel, drive;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic wr_do, rx_try, rx_push, rx_pop;
  logic tx_try, tx_push, tx_pop;
  logic [l-1:0] tx_head, rdata;

  assign sel      = (bus.a[l-1:2] == BASE);
  assign rx_empty = (rx_cnt == '0);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign tx_full  = (tx_cnt == CW'(DEPTH));

  // Write acts one cycle after the registered fall, using live a/d/lanes.
  assign wr_do   = wr_fall & sel;
  assign rx_try  = wr_do & (bus.a[1:0] == 2'd0);
  assign rx_push = rx_try & ~rx_full;
  assign rx_pop  = bus.rx_ready & ~rx_empty;

  // Read side effects use the address held from the fall.
  assign tx_try  = rd_rise & rd_arm & (rd_reg == 2'd0);
  assign tx_pop  = tx_try & ~tx_empty;
  assign tx_push = bus.tx_valid & ~tx_full;

  assign tx_head = tx_empty ? '0 : tx_mem[tx_rp];

  always_comb begin
    rdata = '0;
    unique case (bus.a[1:0])
      2'd0: rdata = tx_head;
      2'd1: rdata = l'({udf, ovf, rx_full, ~tx_empty});
      2'd2: rdata = scratch;
      2'd3: rdata = l'({8'(rx_cnt), 8'(tx_cnt)});
      default: rdata = '0;
    endcase
  end

  assign drive = ~bus.rd_b & bus.wr_b & sel & ~reset;
  assign d     = drive ? rdata : 'z;

  assign bus.irq      = ~tx_empty;
  assign bus.rx_valid = ~rx_empty;
  assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rp];
  assign bus.tx_ready = ~tx_full;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= d;
    if (tx_push) tx_mem[tx_wp] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      rd_s1   <= 1'b1;
      rd_s2   <= 1'b1;
      wr_fall <= 1'b0;
      rd_fall <= 1'b0;
      rd_rise <= 1'b0;
      rd_arm  <= 1'b0;
      rd_reg  <= '0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      tx_wp   <= '0;
      tx_rp   <= '0;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
      scratch <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      wr_s1 <= bus.wr_b;
      wr_s2 <= wr_s1;
      rd_s1 <= bus.rd_b;
      rd_s2 <= rd_s1;
      // Edges are qualified by the other strobe being high.
      wr_fall <= wr_s2 & ~wr_s1 & rd_s1;
      rd_fall <= rd_s2 & ~rd_s1 & wr_s1;
      rd_rise <= ~rd_s2 & rd_s1 & wr_s1;

      if (rd_fall) begin
        rd_arm <= sel;
        rd_reg <= bus.a[1:0];
      end else if (rd_rise) begin
        rd_arm <= 1'b0;
      end

      if (wr_do && bus.a[1:0] == 2'd1) begin
        if (d[3]) udf <= 1'b0;
        if (d[2]) ovf <= 1'b0;
      end
      if (rx_try && rx_full) ovf <= 1'b1;
      if (tx_try && tx_empty) udf <= 1'b1;

      if (wr_do && bus.a[1:0] == 2'd2) begin
        if (!bus.ble_b) scratch[7:0] <= d[7:0];
        if (!bus.bhe_b) scratch[l-1:8] <= d[l-1:8];
      end

      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);

      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end
endmodule
